// File: rtl/bcd_code_pkg.sv
// Shared types and constants for the BCD code checker.
package bcd_code_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ENTRY,
        CHECK,
        LOCKED
    } state_e;

    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Down-counter that stays busy for exactly CYCLES cycles after start_i.
module lockout_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = W'(CYCLES - 1);
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done_o marks the final busy cycle so the owner can leave in step
    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/bcd_code_checker.sv
// Serial BCD code entry checker with failure counting and timed lockout.
module bcd_code_checker
    import bcd_code_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned CW         = $clog2(DIGITS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [4*DIGITS-1:0] code_i,
    input  logic [3:0]        digit_i,
    input  logic              digit_valid_i,
    input  logic              clear_i,
    output logic              ready_o,
    output logic [CW-1:0]     count_o,
    output logic              equal_o,
    output logic              fail_o,
    output logic              locked_o,
    output logic              bad_digit_o
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          mis_q, mis_d;
    logic [3:0]    fails_q, fails_d;
    logic          bad_q, bad_d;
    logic [3:0]    fails_inc;
    logic          lock_start;
    logic          lock_busy;
    logic          lock_done;
    bcd_t          ref_digit;
    bcd_t          dig;

    assign dig       = bcd_t'(digit_i);
    assign fails_inc = fails_q + 4'd1;

    always_comb begin
        ref_digit = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count_q == CW'(k)) ref_digit = code_i[4*k +: 4];
        end
    end

    lockout_timer #(
        .CYCLES(LOCK_CYCLES)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start_i(lock_start),
        .busy_o (lock_busy),
        .done_o (lock_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mis_d      = mis_q;
        fails_d    = fails_q;
        bad_d      = 1'b0;
        lock_start = 1'b0;
        unique case (state_q)
            ENTRY: begin
                if (clear_i) begin
                    count_d = '0;
                    mis_d   = 1'b0;
                end else if (digit_valid_i) begin
                    if (!is_bcd(dig)) begin
                        bad_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                        if (dig != ref_digit) mis_d = 1'b1;
                        if (count_q == CW'(DIGITS - 1)) state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                count_d = '0;
                mis_d   = 1'b0;
                state_d = ENTRY;
                if (!mis_q) begin
                    fails_d = '0;
                end else begin
                    fails_d = fails_inc;
                    if (fails_inc == 4'(MAX_TRIES)) begin
                        state_d    = LOCKED;
                        lock_start = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (lock_done) begin
                    state_d = ENTRY;
                    fails_d = '0;
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENTRY;
            count_q <= '0;
            mis_q   <= 1'b0;
            fails_q <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mis_q   <= mis_d;
            fails_q <= fails_d;
            bad_q   <= bad_d;
        end
    end

    assign ready_o     = (state_q == ENTRY);
    assign count_o     = count_q;
    assign equal_o     = (state_q == CHECK) && !mis_q;
    assign fail_o      = (state_q == CHECK) && mis_q;
    assign locked_o    = lock_busy;
    assign bad_digit_o = bad_q;

endmodule

// File: tb/tb_bcd_code_checker.sv
// Scoreboarded, table-driven bench for bcd_code_checker.
module tb_bcd_code_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] code;
    logic [3:0]  digit;
    logic        dvalid;
    logic        clr;
    logic        ready;
    logic [2:0]  count;
    logic        equal;
    logic        fail;
    logic        locked;
    logic        bad;

    int n_vec = 0;
    int n_err = 0;
    int bad_seen = 0;
    logic sb_q[$];

    typedef struct {
        logic [15:0] code;
        logic [15:0] entry;
        logic        exp_eq;
    } vec_t;

    always #5 clk = ~clk;

    bcd_code_checker #(
        .DIGITS(4),
        .MAX_TRIES(3),
        .LOCK_CYCLES(16)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .code_i       (code),
        .digit_i      (digit),
        .digit_valid_i(dvalid),
        .clear_i      (clr),
        .ready_o      (ready),
        .count_o      (count),
        .equal_o      (equal),
        .fail_o       (fail),
        .locked_o     (locked),
        .bad_digit_o  (bad)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bad) bad_seen++;
        if (equal || fail) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                logic e;
                e = sb_q.pop_front();
                check("sb_equal", int'(equal), int'(e));
                check("sb_fail", int'(fail), int'(!e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit  = d;
        dvalid = 1'b1;
        cyc();
        dvalid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] e, input logic exp_eq);
        logic [15:0] ev;
        ev = e;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) sb_q.push_back(exp_eq);
            send_digit(ev[4*k +: 4]);
        end
        check("result_latency", int'(equal | fail), 1);
        cyc();
        check("sb_drain", sb_q.size(), 0);
    endtask

    task automatic wait_unlock(output int n);
        n = 0;
        while (locked && n < 100) begin
            check("ready_in_lock", int'(ready), 0);
            digit  = (n % 2 == 0) ? 4'd12 : 4'd2;
            dvalid = 1'b1;
            clr    = (n == 5);
            cyc();
            n++;
        end
        dvalid = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_eqfail"}, int'(equal | fail), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_bad"}, int'(bad), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int b0;
        code   = 16'h1082;
        digit  = 4'd0;
        dvalid = 1'b0;
        clr    = 1'b0;

        vecs[0] = '{16'h1082, 16'h1082, 1'b1};
        vecs[1] = '{16'h1082, 16'h2082, 1'b0};
        vecs[2] = '{16'h4444, 16'h4444, 1'b1};
        vecs[3] = '{16'h9990, 16'h9990, 1'b1};
        vecs[4] = '{16'h9990, 16'h0999, 1'b0};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1};
        vecs[6] = '{16'h0000, 16'h0001, 1'b0};
        vecs[7] = '{16'h5678, 16'h5678, 1'b1};

        repeat (3) cyc();
        check_reset_outs("rst");
        rst_n = 1'b1;
        cyc();

        foreach (vecs[i]) begin
            code = vecs[i].code;
            enter_code(vecs[i].entry, vecs[i].exp_eq);
        end

        code = 16'h1082;
        send_digit(4'd2);
        code = 16'h1089;
        send_digit(4'd8);
        send_digit(4'd0);
        sb_q.push_back(1'b1);
        send_digit(4'd1);
        cyc();
        check("code_resample_drain", sb_q.size(), 0);

        code = 16'h4444;
        b0 = bad_seen;
        send_digit(4'd4);
        send_digit(4'd12);
        check("bad_count_hold", int'(count), 1);
        send_digit(4'd4);
        check("count_before_clr", int'(count), 2);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("count_after_clr", int'(count), 0);
        check("bad_pulses", bad_seen - b0, 1);
        enter_code(16'h4444, 1'b1);

        code = 16'h1082;
        send_digit(4'd3);
        clr    = 1'b1;
        digit  = 4'd8;
        dvalid = 1'b1;
        cyc();
        clr    = 1'b0;
        dvalid = 1'b0;
        check("clr_priority_count", int'(count), 0);
        enter_code(16'h1082, 1'b1);

        enter_code(16'h2082, 1'b0);
        enter_code(16'h2082, 1'b0);
        enter_code(16'h1082, 1'b1);
        enter_code(16'h2082, 1'b0);
        enter_code(16'h2082, 1'b0);
        check("no_lock_after_reset_ctr", int'(locked), 0);
        check("ready_after_two", int'(ready), 1);
        enter_code(16'h2082, 1'b0);
        check("lock_after_third", int'(locked), 1);
        wait_unlock(n);
        check("lock_cycles_a", n, 16);

        b0 = bad_seen;
        repeat (3) enter_code(16'h2082, 1'b0);
        check("locked_on", int'(locked), 1);
        wait_unlock(n);
        check("lock_cycles_b", n, 16);
        check("ready_after_lock", int'(ready), 1);
        check("count_after_lock", int'(count), 0);
        cyc();
        check("no_bad_in_lock", bad_seen - b0, 0);
        enter_code(16'h1082, 1'b1);

        send_digit(4'd2);
        send_digit(4'd8);
        check("mid_entry_count", int'(count), 2);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_entry");
        cyc();
        rst_n = 1'b1;
        cyc();
        repeat (3) enter_code(16'h2082, 1'b0);
        repeat (3) cyc();
        check("pre_rst_locked", int'(locked), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs("rst_lock");
        cyc();
        rst_n = 1'b1;
        cyc();
        enter_code(16'h1082, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
